// File: rtl/pulse_pkg.sv
// Shared constants, window state type and sum-width helper
// for the sliding-window pulse accumulator.
package pulse_pkg;

  localparam int CNT_W_DEF = 4;
  localparam int DEPTH_DEF = 3;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } win_state_t;

  function automatic int sum_width(input int cnt_w, input int depth);
    return cnt_w + $clog2(depth);
  endfunction

endpackage

// File: rtl/pulse_ring_buf.sv
// Ring of the last DEPTH interval counts with a wrapping write pointer.
// Ports: clk, rst, clear, wr_en, wr_data in; oldest = entry at wr_ptr out.
module pulse_ring_buf
  import pulse_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_data,
  output logic [CNT_W-1:0] oldest
);

  localparam int PW = $clog2(DEPTH);

  logic [CNT_W-1:0] ring_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    wr_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(1);
    if (wr_ptr_q == PW'(DEPTH - 1)) begin
      wr_ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        ring_q[i] <= '0;
      end
      wr_ptr_q <= '0;
    end else if (wr_en) begin
      ring_q[wr_ptr_q] <= wr_data;
      wr_ptr_q         <= wr_ptr_d;
    end
  end

  // Zeroed ring makes the oldest entry read as 0 while filling.
  assign oldest = ring_q[wr_ptr_q];

endmodule

// File: rtl/pulse_window_sum.sv
// Sliding-window sum of interval pulse counts with peak-hold.
// Ports: clk, rst, clear, cnt_valid, cnt_in in; sum_out, sum_valid, sum_upd, peak_out out.
module pulse_window_sum
  import pulse_pkg::*;
#(
  parameter  int CNT_W = CNT_W_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int SUM_W = sum_width(CNT_W, DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             cnt_valid,
  input  logic [CNT_W-1:0] cnt_in,
  output logic [SUM_W-1:0] sum_out,
  output logic             sum_valid,
  output logic             sum_upd,
  output logic [SUM_W-1:0] peak_out
);

  localparam int FW = $clog2(DEPTH + 1);

  win_state_t       state_q, state_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [SUM_W-1:0] peak_q, peak_d;
  logic             upd_q, upd_d;

  logic [CNT_W-1:0] oldest;
  logic [SUM_W:0]   sum_ext;
  logic             accept;
  logic             last;

  // A sample arriving together with clear is dropped.
  assign accept = cnt_valid & ~clear;

  pulse_ring_buf #(
    .CNT_W(CNT_W),
    .DEPTH(DEPTH)
  ) u_ring (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .wr_en  (accept),
    .wr_data(cnt_in),
    .oldest (oldest)
  );

  assign sum_ext = {1'b0, sum_q}
                 + (SUM_W + 1)'(cnt_in)
                 - (SUM_W + 1)'(oldest);

  assign last = (state_q == FILL)
             && (fill_q == FW'(DEPTH - 1));

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    sum_d   = sum_q;
    peak_d  = peak_q;
    upd_d   = 1'b0;
    if (accept) begin
      sum_d = sum_ext[SUM_W-1:0];
      upd_d = 1'b1;
      if (state_q == FILL) begin
        fill_d = fill_q + FW'(1);
        if (last) begin
          state_d = RUN;
        end
      end
      // Peak tracks only full windows, incl. the one completing now.
      if ((state_q == RUN || last)
          && sum_ext > {1'b0, peak_q}) begin
        peak_d = sum_ext[SUM_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q <= FILL;
      fill_q  <= '0;
      sum_q   <= '0;
      peak_q  <= '0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      sum_q   <= sum_d;
      peak_q  <= peak_d;
      upd_q   <= upd_d;
    end
  end

  assign sum_out   = sum_q;
  assign sum_valid = (state_q == RUN);
  assign sum_upd   = upd_q;
  assign peak_out  = peak_q;

endmodule

// File: tb/tb_pulse_window_sum.sv
// Scoreboard bench for pulse_window_sum: default build with directed
// vectors, plus a DEPTH=8 / CNT_W=6 build against a window model.
module tb_pulse_window_sum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       cnt_valid = 1'b0;
  logic [3:0] cnt_in = '0;
  logic [5:0] sum_out;
  logic       sum_valid;
  logic       sum_upd;
  logic [5:0] peak_out;

  logic       rst_b = 1'b1;
  logic       clear_b = 1'b0;
  logic       vb = 1'b0;
  logic [5:0] cb = '0;
  logic [8:0] sb;
  logic       valb;
  logic       updb;
  logic [8:0] pb;

  pulse_window_sum u_dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .cnt_valid(cnt_valid),
    .cnt_in   (cnt_in),
    .sum_out  (sum_out),
    .sum_valid(sum_valid),
    .sum_upd  (sum_upd),
    .peak_out (peak_out)
  );

  pulse_window_sum #(
    .CNT_W(6),
    .DEPTH(8)
  ) u_big (
    .clk      (clk),
    .rst      (rst_b),
    .clear    (clear_b),
    .cnt_valid(vb),
    .cnt_in   (cb),
    .sum_out  (sb),
    .sum_valid(valb),
    .sum_upd  (updb),
    .peak_out (pb)
  );

  typedef struct {
    int s;
    int v;
    int p;
  } exp_t;

  exp_t qs[$];
  exp_t qb[$];

  int checks = 0;
  int errors = 0;
  logic hold_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  logic ctl_q = 1'b1;
  always @(posedge clk) ctl_q <= rst | clear;

  int ps = 0, pv = 0, pp = 0;

  always @(negedge clk) begin
    exp_t e;
    if (sum_upd) begin
      if (qs.size() == 0) begin
        chk("unexpected_upd", 1, 0);
      end else begin
        e = qs.pop_front();
        chk("sum", int'(sum_out), e.s);
        chk("valid", int'(sum_valid), e.v);
        chk("peak", int'(peak_out), e.p);
      end
    end else if (hold_en && !ctl_q) begin
      chk("hold_sum", int'(sum_out), ps);
      chk("hold_valid", int'(sum_valid), pv);
      chk("hold_peak", int'(peak_out), pp);
    end
    ps = int'(sum_out);
    pv = int'(sum_valid);
    pp = int'(peak_out);
  end

  always @(negedge clk) begin
    exp_t e;
    if (updb) begin
      if (qb.size() == 0) begin
        chk("big_unexpected_upd", 1, 0);
      end else begin
        e = qb.pop_front();
        chk("big_sum", int'(sb), e.s);
        chk("big_valid", int'(valb), e.v);
        chk("big_peak", int'(pb), e.p);
      end
    end
  end

  task automatic send(input logic [3:0] c, input int s, input int v, input int p);
    exp_t e;
    @(negedge clk);
    cnt_valid = 1'b1;
    cnt_in    = c;
    e = '{s, v, p};
    qs.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      cnt_valid = 1'b0;
      cnt_in    = 4'($urandom);
    end
  endtask

  task automatic do_rst();
    @(negedge clk);
    cnt_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_sum"}, int'(sum_out), 0);
    chk({nm, "_valid"}, int'(sum_valid), 0);
    chk({nm, "_upd"}, int'(sum_upd), 0);
    chk({nm, "_peak"}, int'(peak_out), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int win[$];
    int msum;
    int mpeak;
    exp_t e;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_zero("reset");

    // Fill, then slide with pointer wrap
    send(4'd5, 5, 0, 0);
    send(4'd7, 12, 0, 0);
    send(4'd9, 21, 1, 21);
    send(4'd2, 18, 1, 21);
    send(4'd2, 13, 1, 21);
    send(4'd2, 6, 1, 21);
    idle(2);

    // Max input, no overflow, upd with unchanged sum
    do_rst();
    send(4'd15, 15, 0, 0);
    send(4'd15, 30, 0, 0);
    send(4'd15, 45, 1, 45);
    send(4'd15, 45, 1, 45);
    idle(1);

    // Clear wins over a simultaneous sample
    @(negedge clk);
    clear     = 1'b1;
    cnt_valid = 1'b1;
    cnt_in    = 4'd8;
    @(negedge clk);
    clear     = 1'b0;
    cnt_valid = 1'b0;
    chk_zero("clear");
    send(4'd4, 4, 0, 0);

    // Idle gaps with toggling cnt_in; zero sample counts toward fill
    hold_en = 1'b1;
    idle(1 + $urandom_range(0, 10));
    send(4'd3, 7, 0, 0);
    idle($urandom_range(0, 10));
    send(4'd0, 7, 1, 7);
    idle($urandom_range(0, 10));
    send(4'd6, 9, 1, 9);
    idle($urandom_range(0, 10));
    send(4'd1, 7, 1, 9);
    idle(3);
    hold_en = 1'b0;

    // Reset mid-fill discards history
    do_rst();
    send(4'd1, 1, 0, 0);
    send(4'd2, 3, 0, 0);
    idle(1);
    do_rst();
    chk_zero("rst_mid");
    send(4'd3, 3, 0, 0);
    idle(2);

    // Wide build against a window model
    @(negedge clk);
    rst_b = 1'b0;
    chk("big_reset_sum", int'(sb), 0);
    chk("big_reset_valid", int'(valb), 0);
    chk("big_reset_peak", int'(pb), 0);
    mpeak = 0;
    for (int n = 0; n < 10000;) begin
      @(negedge clk);
      vb = ($urandom_range(0, 3) != 0);
      cb = 6'($urandom);
      if (vb) begin
        n++;
        win.push_back(int'(cb));
        if (win.size() > 8) void'(win.pop_front());
        msum = 0;
        foreach (win[i]) msum += win[i];
        if (win.size() == 8 && msum > mpeak) mpeak = msum;
        e = '{msum, (win.size() == 8) ? 1 : 0, mpeak};
        qb.push_back(e);
      end
    end
    @(negedge clk);
    vb = 1'b0;

    repeat (3) @(negedge clk);
    chk("small_queue_drained", qs.size(), 0);
    chk("big_queue_drained", qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
